dmem_byte_ctrl: RTL
===================

// Module: dmem_byte_ctrl
// PURPOSE
//  Parametrised byte-addressed data memory with request/response handshake for the core's
//  MEM stage. Decodes access size (byte/half/word), builds byte-lane masks, sign/zero-extends
//  loads, flags misaligned/out-of-range/illegal accesses, has configurable read latency and
//  an optional post-reset zero-clear sweep. Successor to the fixed 4K-word async-read data memory.
// PARAMETERS
//  DEPTH          4096  number of 32-bit words (power of two, >=16); valid byte addr < DEPTH*4
//  RD_LAT         1     cycles from accept edge to rsp_valid (legal 1..4)
//  CLEAR_ON_RESET 1     1: zero every word after reset release; 0: contents left as-is
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept; accept = req_valid & req_ready at rising edge
//  req_we         in   1   1 store, 0 load
//  req_size       in   2   0 byte, 1 half, 2 word, 3 illegal
//  req_unsigned   in   1   load zero-extend (LBU/LHU); ignored for stores and word loads
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid      out  1   one-cycle pulse, exactly one per accepted request
//  rsp_rdata      out  32  extended load data; 0 for stores and faults
//  rsp_fault      out  1   access rejected, memory untouched
//  rsp_fault_code out  2   0 none, 1 misaligned, 2 out-of-range, 3 illegal size
//  init_done      out  1   high once clear sweep finished; stays high until next rst
// BEHAVIOUR
//  Reset (async assert): state=INIT, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0,
//   rsp_fault_code=0, init_done=0, sweep index=0. Any in-flight response is dropped.
//  FSM: INIT -> IDLE -> WAIT -> IDLE. req_ready = (state==IDLE); one request outstanding.
//  INIT, CLEAR_ON_RESET=1: writes 0 to word idx, idx++ each cycle from 0 to DEPTH-1; after
//   writing DEPTH-1 go IDLE, init_done=1 (first req_ready exactly DEPTH cycles after release).
//  INIT, CLEAR_ON_RESET=0: go IDLE on first edge after release; init_done=1 with it.
//  Fault priority: illegal size (3) > out-of-range (addr >= DEPTH*4) > misaligned
//   (half with addr[0]=1; word with addr[1:0]!=0). Faulted request: no write, rdata=0.
//  Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
//  Store mask: byte 4'b0001<<lane; half 4'b0011<<lane; word 4'b1111. Data replicated
//   across lanes (byte x4, half x2). Masked bytes written on the accept edge.
//  Load: word read on accept edge; byte = word[8*lane+:8], half = word[8*lane+:16];
//   sign-extend unless req_unsigned; result registered through RD_LAT-1 extra stages.
//  Accept at edge T: state->WAIT; rsp_valid high during the cycle after edge T+RD_LAT-1
//   (RD_LAT=1: cycle right after accept). Next edge: state->IDLE, rsp_valid=0.
//  rsp_rdata/rsp_fault/rsp_fault_code valid only with rsp_valid; hold last value otherwise.
//  Store then load to same address: load returns new data (accesses are serialised).
//  req_* ignored while req_ready=0; no buffering, requester holds req_valid.
//  rst mid-WAIT or mid-INIT: immediate return to reset values; sweep restarts at 0.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=16: release rst -> req_ready/init_done rise exactly 16 cycles
//    later; LW any addr -> 0x00000000.
//  2 SW 0x000 data 0xDEADBEEF; LW 0x000 -> 0xDEADBEEF, rsp_valid 1 cycle after accept
//    (RD_LAT=1) and 3 cycles after (RD_LAT=3), fault=0.
//  3 SB 0x002 data 0x000000A5 over 0xDEADBEEF; LW -> 0xDEA5BEEF; LB 0x002 -> 0xFFFFFFA5;
//    LBU 0x002 -> 0x000000A5; LH 0x002 -> 0xFFFFDEA5.
//  4 SH 0x001 data 0x1234 -> fault, code 1; LW 0x000 unchanged; size=3 -> code 3;
//    LW addr DEPTH*4 -> code 2, rdata 0.
//  5 Assert rst while in WAIT -> rsp_valid stays 0, no response emitted, sweep restarts,
//    previously written word reads 0 after init_done.
//  6 Back-to-back req_valid held high -> one accept per RD_LAT+1 cycles, one rsp_valid each.

Source files
------------

// File: rtl/dmem_byte_ctrl.sv
// Byte-addressed data memory for the MEM stage: size decode, lane masks, load extension,
// fault detection, RD_LAT-cycle registered response and an optional post-reset clear sweep.
module dmem_byte_ctrl #(
  parameter int DEPTH          = 4096,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  output logic [1:0]  o_rsp_fault_code,
  output logic        o_init_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_clr_idx;
  logic [31:0]       r_mem [DEPTH];

  logic [RD_LAT-1:0] r_pvld;
  logic [31:0]       r_pdat  [RD_LAT];
  logic [1:0]        r_pcode [RD_LAT];

  logic              w_req_ready;
  logic              w_init_done;
  logic              w_clr_we;
  logic              w_accept;
  logic [1:0]        w_lane;
  logic [AW-1:0]     w_idx;
  logic              w_oob;
  logic [1:0]        w_code;
  logic              w_fault;
  logic [3:0]        w_mask;
  logic [31:0]       w_wdat_rep;
  logic [31:0]       w_rd_word;
  logic [15:0]       w_shift;
  logic [31:0]       w_ld_dat;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_we) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: begin
        if ((CLEAR_ON_RESET == 0) || (r_clr_idx == AW'(DEPTH - 1))) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Leave WAIT on the edge that retires the response pulse.
        if (r_pvld[RD_LAT-1]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_req_ready = 1'b0;
    w_init_done = 1'b1;
    w_clr_we    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_done = 1'b0;
        w_clr_we    = (CLEAR_ON_RESET != 0);
      end
      S_IDLE:  w_req_ready = 1'b1;
      default: w_req_ready = 1'b0;
    endcase
  end

  // ---------------- Request decode ----------------
  assign w_accept = i_req_valid & w_req_ready;
  assign w_lane   = i_req_addr[1:0];
  assign w_idx    = i_req_addr[AW+1:2];
  assign w_oob    = |i_req_addr[31:AW+2];

  always_comb begin
    w_code = 2'd0;
    if (i_req_size == 2'd3) begin
      w_code = 2'd3;
    end else if (w_oob) begin
      w_code = 2'd2;
    end else if (((i_req_size == 2'd1) && i_req_addr[0]) ||
                 ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00))) begin
      w_code = 2'd1;
    end
  end

  assign w_fault = (w_code != 2'd0);

  always_comb begin
    w_mask     = 4'b1111;
    w_wdat_rep = i_req_wdata;
    case (i_req_size)
      2'd0: begin
        w_mask     = 4'b0001 << w_lane;
        w_wdat_rep = {4{i_req_wdata[7:0]}};
      end
      2'd1: begin
        w_mask     = 4'b0011 << w_lane;
        w_wdat_rep = {2{i_req_wdata[15:0]}};
      end
      default: begin
        w_mask     = 4'b1111;
        w_wdat_rep = i_req_wdata;
      end
    endcase
  end

  // ---------------- Storage ----------------
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_accept && i_req_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdat_rep[8*b +: 8];
        end
      end
    end
  end

  // ---------------- Load extraction ----------------
  assign w_rd_word = r_mem[w_idx];
  assign w_shift   = 16'(w_rd_word >> {w_lane, 3'b000});

  always_comb begin
    w_ld_dat = w_rd_word;
    case (i_req_size)
      2'd0: w_ld_dat = i_req_unsigned ? {24'd0, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1: w_ld_dat = i_req_unsigned ? {16'd0, w_shift}
                                      : {{16{w_shift[15]}}, w_shift};
      default: w_ld_dat = w_rd_word;
    endcase
  end

  // ---------------- Response pipeline ----------------
  // Stages only load behind a valid token, so the last stage holds its value between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pvld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pdat[i]  <= '0;
        r_pcode[i] <= '0;
      end
    end else begin
      r_pvld[0] <= w_accept;
      if (w_accept) begin
        r_pdat[0]  <= (w_fault || i_req_we) ? 32'd0 : w_ld_dat;
        r_pcode[0] <= w_code;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        if (r_pvld[i-1]) begin
          r_pdat[i]  <= r_pdat[i-1];
          r_pcode[i] <= r_pcode[i-1];
        end
      end
    end
  end

  assign o_req_ready      = w_req_ready;
  assign o_init_done      = w_init_done;
  assign o_rsp_valid      = r_pvld[RD_LAT-1];
  assign o_rsp_rdata      = r_pdat[RD_LAT-1];
  assign o_rsp_fault_code = r_pcode[RD_LAT-1];
  assign o_rsp_fault      = (r_pcode[RD_LAT-1] != 2'd0);

endmodule
